// File: rtl/dds_pkg.sv
// dds_pkg: waveform select codes, pipeline latency and scale helpers for dds_gen.
// Build option DDS_AMP_SCALE_EN adds the amplitude-scaling stage (latency 4).
package dds_pkg;
    localparam logic [3:0] WAVE_SINE   = 4'b0001;
    localparam logic [3:0] WAVE_SQUARE = 4'b0010;
    localparam logic [3:0] WAVE_TRI    = 4'b0100;
    localparam logic [3:0] WAVE_SAW    = 4'b1000;
`ifdef DDS_AMP_SCALE_EN
    localparam int LATENCY = 4;
`else
    localparam int LATENCY = 3;
`endif
    function automatic int midscale(int w);
        return 1 << (w - 1);
    endfunction
    function automatic int fullscale(int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/dds_sine_rom.sv
// dds_sine_rom: quarter-wave sine magnitude table, filled at elaboration, registered read.
module dds_sine_rom #(
    parameter int AW = 10,
    parameter int DW = 7
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] q
);
    logic [DW-1:0] rom [2**AW];
    // Half-step offset makes the quadrant mirror exact without duplicating end points.
    function automatic logic [DW-1:0] entry(int i);
        real a;
        a = 3.14159265358979 / 2.0 * (real'(i) + 0.5) / real'(2**AW);
        return DW'($rtoi(real'(2**DW - 1) * $sin(a) + 0.5));
    endfunction
    for (genvar i = 0; i < 2**AW; i++) begin : g_rom
        assign rom[i] = entry(i);
    end
    always_ff @(posedge clk) q <= rom[addr];
endmodule

// File: rtl/dds_gen.sv
// dds_gen: phase-continuous DDS with deferred tuning; acc -> phase -> wave -> output.
// Build option DDS_AMP_SCALE_EN adds the amp input and a fourth scaling stage.
module dds_gen
    import dds_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              enable,
    input  logic [3:0]        wave_sel,
    input  logic [ACC_W-1:0]  freq_word,
    input  logic [ADDR_W-1:0] phase_word,
    input  logic              load,
`ifdef DDS_AMP_SCALE_EN
    input  logic [7:0]        amp,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              sync_pulse
);
    localparam logic [DATA_W-1:0] MID  = DATA_W'(midscale(DATA_W));
    localparam logic [DATA_W-1:0] FULL = DATA_W'(fullscale(DATA_W));

    logic [ACC_W-1:0]  acc, freq_a, freq_s;
    logic [ADDR_W-1:0] phase_a, phase_s;
    logic [3:0]        wave_a, wave_s;
    logic              pending, wrap_r;
    logic [ACC_W:0]    sum;
    logic              wrap, apply;

    assign sum   = {1'b0, acc} + {1'b0, freq_a};
    assign wrap  = enable & sum[ACC_W];
    // A load in the wrap cycle itself takes effect directly, bypassing the shadows.
    assign apply = (pending | load) & (!enable | wrap);

    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            acc     <= '0;
            freq_a  <= '0;
            freq_s  <= '0;
            phase_a <= '0;
            phase_s <= '0;
            wave_a  <= '0;
            wave_s  <= '0;
            pending <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            if (enable) acc <= sum[ACC_W-1:0];
            if (load) begin
                freq_s  <= freq_word;
                phase_s <= phase_word;
                wave_s  <= wave_sel;
            end
            if (apply) begin
                freq_a  <= load ? freq_word : freq_s;
                phase_a <= load ? phase_word : phase_s;
                wave_a  <= load ? wave_sel : wave_s;
            end
            pending <= (pending | load) & !apply;
            wrap_r  <= wrap;
        end

    logic [ADDR_W-1:0] p1;
    logic [3:0]        w1;
    logic              v1, y1;

    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            p1 <= '0;
            w1 <= '0;
            v1 <= 1'b0;
            y1 <= 1'b0;
        end else begin
            p1 <= acc[ACC_W-1 -: ADDR_W] + phase_a;
            w1 <= wave_a;
            v1 <= enable;
            y1 <= wrap_r & enable;
        end

    logic [ADDR_W-3:0] rom_addr;
    logic [DATA_W-2:0] rom_q;
    logic [DATA_W-1:0] tri_t, wave_v, s2;
    logic              neg2, sine2, v2, y2;

    assign rom_addr = p1[ADDR_W-2] ? ~p1[ADDR_W-3:0] : p1[ADDR_W-3:0];
    assign tri_t    = p1[ADDR_W-2 -: DATA_W];
    assign wave_v   = w1 == WAVE_SAW    ? p1[ADDR_W-1 -: DATA_W]
                    : w1 == WAVE_SQUARE ? (p1[ADDR_W-1] ? '0 : FULL)
                    : w1 == WAVE_TRI    ? (p1[ADDR_W-1] ? ~tri_t : tri_t)
                    : MID;

    dds_sine_rom #(.AW(ADDR_W - 2), .DW(DATA_W - 1)) u_rom (
        .clk  (sys_clk),
        .addr (rom_addr),
        .q    (rom_q)
    );

    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            s2    <= MID;
            neg2  <= 1'b0;
            sine2 <= 1'b0;
            v2    <= 1'b0;
            y2    <= 1'b0;
        end else begin
            s2    <= wave_v;
            neg2  <= p1[ADDR_W-1];
            sine2 <= w1 == WAVE_SINE;
            v2    <= v1;
            y2    <= y1;
        end

    // mid+v is {1,v}; mid-1-v is its complement {0,~v}.
    logic [DATA_W-1:0] sine_v, s3;
    logic              v3, y3;

    assign sine_v = {~neg2, rom_q ^ {(DATA_W - 1){neg2}}};

    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            s3 <= MID;
            v3 <= 1'b0;
            y3 <= 1'b0;
        end else begin
            if (v2) s3 <= sine2 ? sine_v : s2;
            v3 <= v2;
            y3 <= y2 & v2;
        end

`ifdef DDS_AMP_SCALE_EN
    logic [7:0]                amp_a, amp_s, a1, a2, a3;
    logic signed [DATA_W:0]    diff;
    logic signed [DATA_W+9:0]  prod;

    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            amp_s <= 8'd255;
            amp_a <= 8'd255;
            a1    <= 8'd255;
            a2    <= 8'd255;
            a3    <= 8'd255;
        end else begin
            if (load) amp_s <= amp;
            if (apply) amp_a <= load ? amp : amp_s;
            a1 <= amp_a;
            a2 <= a1;
            a3 <= a2;
        end

    assign diff = $signed({1'b0, s3}) - $signed({1'b0, MID});
    assign prod = diff * $signed({1'b0, a3});

    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            data_out   <= MID;
            data_valid <= 1'b0;
            sync_pulse <= 1'b0;
        end else begin
            if (v3) data_out <= MID + DATA_W'(prod >>> 8);
            data_valid <= v3;
            sync_pulse <= y3;
        end
`else
    assign data_out   = s3;
    assign data_valid = v3;
    assign sync_pulse = y3;
`endif
endmodule
